// File: rtl/rob_pkg.sv
// Reorder buffer shared types.
// Reservation stations and dispatch import this to size their tags.
package rob_pkg;

   localparam int ROB_INDEX_BITS_DEF = 4;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic [4:0]  rd;
      logic [31:0] data;
   } rob_entry_t;

endpackage

// File: rtl/rob_if.sv
// Dispatch / CDB / lookup / retire bundle of the reorder buffer.
// The master side is dispatch plus regfile; the slave side is the ROB.
interface rob_if
   import rob_pkg::*;
#(
   parameter int IW = ROB_INDEX_BITS_DEF
) ();

   logic          flush;
   logic          alloc_req;
   logic [4:0]    alloc_rd;
   logic          alloc_ready;
   logic [IW-1:0] alloc_idx;

   logic          cdb_valid;
   logic [IW-1:0] cdb_idx;
   logic [31:0]   cdb_data;

   logic [IW-1:0] q1_idx;
   logic [IW-1:0] q2_idx;
   logic          q1_ready;
   logic          q2_ready;
   logic [31:0]   q1_data;
   logic [31:0]   q2_data;

   logic          commit_valid;
   logic [4:0]    commit_rd;
   logic [31:0]   commit_data;
   logic [IW-1:0] rob_head;
   logic          full;
   logic          empty;

   modport master (
      output flush, alloc_req, alloc_rd,
      output cdb_valid, cdb_idx, cdb_data,
      output q1_idx, q2_idx,
      input  alloc_ready, alloc_idx,
      input  q1_ready, q2_ready, q1_data, q2_data,
      input  commit_valid, commit_rd, commit_data,
      input  rob_head, full, empty
   );

   modport slave (
      input  flush, alloc_req, alloc_rd,
      input  cdb_valid, cdb_idx, cdb_data,
      input  q1_idx, q2_idx,
      output alloc_ready, alloc_idx,
      output q1_ready, q2_ready, q1_data, q2_data,
      output commit_valid, commit_rd, commit_data,
      output rob_head, full, empty
   );

endinterface

// File: rtl/rob.sv
// Reorder buffer: allocates tags at dispatch, captures CDB results,
// answers renamed-operand lookups and retires in program order.
module rob
   import rob_pkg::*;
#(
   parameter int ROB_INDEX_BITS = ROB_INDEX_BITS_DEF
) (
   input logic  clk,
   input logic  rst,
   rob_if.slave bus
);

   localparam int DEPTH = 2 ** ROB_INDEX_BITS;

   typedef logic [ROB_INDEX_BITS-1:0] idx_t;

   rob_entry_t              ent [DEPTH];
   idx_t                    head;
   idx_t                    tail;
   logic [ROB_INDEX_BITS:0] count;

   rob_entry_t head_ent;
   logic       full;
   logic       do_alloc;
   logic       do_commit;
   logic       cdb_hit;

   // count tops out at DEPTH, so its MSB alone marks full
   assign full      = count[ROB_INDEX_BITS];
   assign head_ent  = ent[head];
   assign do_commit = head_ent.busy && head_ent.ready;
   assign do_alloc  = bus.alloc_req && !full;
   assign cdb_hit   = bus.cdb_valid && ent[bus.cdb_idx].busy;

   assign bus.alloc_ready  = !full;
   assign bus.alloc_idx    = tail;
   assign bus.full         = full;
   assign bus.empty        = (count == '0);
   assign bus.rob_head     = head;
   assign bus.commit_valid = do_commit;
   assign bus.commit_rd    = head_ent.rd;
   assign bus.commit_data  = head_ent.data;

   function automatic logic [32:0] lookup(
      input rob_entry_t  e,
      input logic        byp,
      input logic [31:0] byp_data
   );
      if (!e.busy)
         return '0;
      if (byp)
         return {1'b1, byp_data};
      return {e.ready, e.data};
   endfunction

   // same-cycle CDB results bypass the entry array
   assign {bus.q1_ready, bus.q1_data} = lookup(
      ent[bus.q1_idx],
      bus.cdb_valid && (bus.cdb_idx == bus.q1_idx),
      bus.cdb_data);

   assign {bus.q2_ready, bus.q2_data} = lookup(
      ent[bus.q2_idx],
      bus.cdb_valid && (bus.cdb_idx == bus.q2_idx),
      bus.cdb_data);

   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         for (int i = 0; i < DEPTH; i++)
            ent[i] <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (cdb_hit) begin
            ent[bus.cdb_idx].ready <= 1'b1;
            ent[bus.cdb_idx].data  <= bus.cdb_data;
         end
         if (do_commit) begin
            ent[head].busy <= 1'b0;
            head           <= head + 1'b1;
         end
         if (do_alloc) begin
            ent[tail] <= '{busy:  1'b1,
                           ready: 1'b0,
                           rd:    bus.alloc_rd,
                           data:  '0};
            tail      <= tail + 1'b1;
         end
         unique case ({do_alloc, do_commit})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_rob.sv
// Scoreboard bench for the reorder buffer.
// Retire order and payload are checked by a separate monitor process.
module tb_rob;
   import rob_pkg::*;

   typedef struct {
      logic [3:0]  tag;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   exp_t expq[$];

   rob_if #(.IW(4)) bus ();

   rob #(.ROB_INDEX_BITS(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // retire monitor
   always @(negedge clk) begin
      if (!rst && bus.commit_valid) begin
         if (expq.size() == 0) begin
            chk("unexpected_commit", 32'(bus.rob_head), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("commit_tag", 32'(bus.rob_head), 32'(e.tag));
            chk("commit_rd", 32'(bus.commit_rd), 32'(e.rd));
            chk("commit_data", bus.commit_data, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] rd, input logic [3:0] tag,
                        input bit push, input logic [31:0] d);
      bus.alloc_req = 1'b1;
      bus.alloc_rd  = rd;
      #1;
      chk("alloc_idx", 32'(bus.alloc_idx), 32'(tag));
      if (push)
         expq.push_back('{tag: tag, rd: rd, data: d});
      tick();
      bus.alloc_req = 1'b0;
   endtask

   task automatic cdb(input logic [3:0] idx, input logic [31:0] d);
      bus.cdb_valid = 1'b1;
      bus.cdb_idx   = idx;
      bus.cdb_data  = d;
      tick();
      bus.cdb_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.flush     = 1'b0;
      bus.alloc_req = 1'b0;
      bus.alloc_rd  = '0;
      bus.cdb_valid = 1'b0;
      bus.cdb_idx   = '0;
      bus.cdb_data  = '0;
      bus.q1_idx    = '0;
      bus.q2_idx    = '0;
      tick();
      do_reset();
      #1;
      chk("rst_commit_valid", 32'(bus.commit_valid), 0);
      chk("rst_rob_head", 32'(bus.rob_head), 0);
      chk("rst_alloc_idx", 32'(bus.alloc_idx), 0);
      chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_q1_ready", 32'(bus.q1_ready), 0);

      // single alloc, complete, retire
      alloc(5'd5, 4'd0, 1'b1, 32'hDEADBEEF);
      chk("t1_empty_after_alloc", 32'(bus.empty), 0);
      cdb(4'd0, 32'hDEADBEEF);
      chk("t1_commit_valid", 32'(bus.commit_valid), 1);
      tick();
      chk("t1_empty", 32'(bus.empty), 1);
      chk("t1_head", 32'(bus.rob_head), 1);

      // out-of-order completion, in-order retire
      do_reset();
      alloc(5'd1, 4'd0, 1'b1, 32'h11);
      alloc(5'd2, 4'd1, 1'b1, 32'h22);
      alloc(5'd3, 4'd2, 1'b1, 32'h33);
      cdb(4'd2, 32'h33);
      chk("t2_no_early_commit", 32'(bus.commit_valid), 0);
      cdb(4'd1, 32'h22);
      cdb(4'd0, 32'h11);
      chk("t2_c0_rd", 32'(bus.commit_rd), 1);
      tick();
      chk("t2_c1_rd", 32'(bus.commit_rd), 2);
      tick();
      chk("t2_c2_rd", 32'(bus.commit_rd), 3);
      tick();
      chk("t2_empty", 32'(bus.empty), 1);

      // fill, overflow attempt, wrap
      do_reset();
      for (int i = 0; i < 16; i++)
         alloc(5'(i + 1), 4'(i), i == 0, 32'hA0);
      chk("t3_full", 32'(bus.full), 1);
      chk("t3_alloc_ready", 32'(bus.alloc_ready), 0);
      bus.alloc_req = 1'b1;
      bus.alloc_rd  = 5'd7;
      tick();
      bus.alloc_req = 1'b0;
      chk("t3_17th_tail", 32'(bus.alloc_idx), 0);
      chk("t3_17th_full", 32'(bus.full), 1);
      cdb(4'd0, 32'hA0);
      chk("t3_commit_cycle_ready", 32'(bus.alloc_ready), 0);
      tick();
      chk("t3_ready_after", 32'(bus.alloc_ready), 1);
      chk("t3_head_after", 32'(bus.rob_head), 1);
      alloc(5'd9, 4'd0, 1'b0, 32'h0);
      chk("t3_full_again", 32'(bus.full), 1);

      // lookup bypass
      do_reset();
      for (int i = 0; i < 4; i++)
         alloc(5'(i + 20), 4'(i), 1'b0, 32'h0);
      bus.q1_idx    = 4'd3;
      bus.q2_idx    = 4'd2;
      bus.cdb_valid = 1'b1;
      bus.cdb_idx   = 4'd3;
      bus.cdb_data  = 32'h1234;
      #1;
      chk("t4_byp_ready", 32'(bus.q1_ready), 1);
      chk("t4_byp_data", bus.q1_data, 32'h1234);
      chk("t4_q2_ready", 32'(bus.q2_ready), 0);
      tick();
      bus.cdb_valid = 1'b0;
      #1;
      chk("t4_held_ready", 32'(bus.q1_ready), 1);
      chk("t4_held_data", bus.q1_data, 32'h1234);
      bus.q2_idx = 4'd9;
      #1;
      chk("t4_idle_ready", 32'(bus.q2_ready), 0);
      chk("t4_idle_data", bus.q2_data, 0);

      // flush with competing alloc and CDB
      alloc(5'd24, 4'd4, 1'b0, 32'h0);
      bus.flush     = 1'b1;
      bus.alloc_req = 1'b1;
      bus.alloc_rd  = 5'd30;
      bus.cdb_valid = 1'b1;
      bus.cdb_idx   = 4'd1;
      bus.cdb_data  = 32'h99;
      tick();
      bus.flush     = 1'b0;
      bus.alloc_req = 1'b0;
      bus.cdb_valid = 1'b0;
      bus.q1_idx    = 4'd1;
      #1;
      chk("t5_empty", 32'(bus.empty), 1);
      chk("t5_head", 32'(bus.rob_head), 0);
      chk("t5_tail", 32'(bus.alloc_idx), 0);
      chk("t5_commit_valid", 32'(bus.commit_valid), 0);
      chk("t5_q1_ready", 32'(bus.q1_ready), 0);
      alloc(5'd3, 4'd0, 1'b0, 32'h0);
      alloc(5'd4, 4'd1, 1'b0, 32'h0);
      #1;
      chk("t5_cdb_dropped", 32'(bus.q1_ready), 0);
      chk("t5_cdb_dropped_d", bus.q1_data, 0);

      // simultaneous alloc and commit at count 4
      do_reset();
      alloc(5'd10, 4'd0, 1'b1, 32'h100);
      for (int i = 1; i < 4; i++)
         alloc(5'(i + 10), 4'(i), 1'b0, 32'h0);
      cdb(4'd0, 32'h100);
      chk("t6_commit", 32'(bus.commit_valid), 1);
      alloc(5'd14, 4'd4, 1'b0, 32'h0);
      chk("t6_head", 32'(bus.rob_head), 1);
      chk("t6_tail", 32'(bus.alloc_idx), 5);
      for (int i = 0; i < 11; i++)
         alloc(5'd15, 4'(i + 5), 1'b0, 32'h0);
      chk("t6_not_full_at_15", 32'(bus.full), 0);
      alloc(5'd15, 4'd0, 1'b0, 32'h0);
      chk("t6_full_at_16", 32'(bus.full), 1);

      for (int i = 0; i < 20 && expq.size() != 0; i++)
         tick();
      chk("scoreboard_drained", 32'(expq.size()), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the Tomasulo core.
- Sits between dispatch/CDB and the architectural register file.
- At dispatch it allocates a tag (ROB index) for each destination write. It captures results broadcast on the CDB and answers operand lookups for renamed sources.
- It retires entries strictly in program order. Retirement drives the regfile writeback port (regidx_wb, regdata_wb, load_reg_wb) and rob_head.

Parameters:
- ROB_INDEX_BITS, 4, log2 of entry count (DEPTH = 2**ROB_INDEX_BITS = 16).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- flush  in  1  discard all in-flight entries (mispredict recovery)
- alloc_req  in  1  dispatch requests an entry this cycle
- alloc_rd  in  5  architectural destination of the dispatching instruction
- alloc_ready  out  1  entry available (== !full)
- alloc_idx  out  ROB_INDEX_BITS  tag given to the dispatching instruction (current tail)
- cdb_valid  in  1  CDB broadcast valid
- cdb_idx  in  ROB_INDEX_BITS  tag of the broadcast result
- cdb_data  in  32  broadcast result
- q1_idx, q2_idx  in  ROB_INDEX_BITS  operand lookup tags (from regfile rs*_out when rs*_v=0)
- q1_ready, q2_ready  out  1  looked-up entry holds its result
- q1_data, q2_data  out  32  looked-up result
- commit_valid  out  1  head retires this cycle (to load_reg_wb)
- commit_rd  out  5  to regidx_wb
- commit_data  out  32  to regdata_wb
- rob_head  out  ROB_INDEX_BITS  head index (to regfile rob_head)
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Storage: DEPTH entries of {busy, ready, rd, data}.
- Pointers: head, tail (ROB_INDEX_BITS each, natural wrap DEPTH-1 -> 0) plus count (ROB_INDEX_BITS+1 bits).
- Reset (rst, synchronous, active-high) clears all entries to not-busy/not-ready and sets head = tail = count = 0.
  - Resulting outputs: commit_valid 0, rob_head 0, alloc_idx 0, alloc_ready 1, full 0, empty 1, q*_ready 0.
- flush has identical effect to rst. rst and flush take priority over alloc, CDB and commit in the same cycle.
- Allocate: on alloc_req && !full, at the edge:
  - entry[tail] <= {busy=1, ready=0, rd=alloc_rd, data=0}
  - tail++
  - alloc_idx is valid combinationally in the same cycle.
  - alloc_req while full is ignored; no state change.
  - alloc_ready = !full, so a commit freeing a slot does not enable allocation until the next cycle.
- CDB capture: on cdb_valid with entry[cdb_idx].busy, at the edge: data <= cdb_data, ready <= 1.
  - cdb_valid to a non-busy entry is ignored.
  - A second write to an already-ready entry overwrites it (not expected in legal traffic).
- Commit: combinational from registered state.
  - commit_valid = entry[head].busy && entry[head].ready; commit_rd = entry[head].rd; commit_data = entry[head].data; rob_head = head.
  - During a commit cycle rob_head equals the tag of the retiring entry, so the regfile's tag match on rob_head is valid.
  - At the edge: entry[head].busy <= 0, head++.
  - At most one commit per cycle; zero-cycle latency once the result is captured. A result captured at edge N retires in cycle N+1 if it is at the head.
  - rd = 0 entries still retire with commit_valid = 1; the regfile ignores x0.
- Simultaneous alloc and commit (not full): count unchanged; head and tail both advance.
- Simultaneous CDB and commit on the head entry: commit uses the old state (not ready), so the entry retires next cycle.
- Lookup: qN_ready = entry[qN_idx].busy && (entry[qN_idx].ready || (cdb_valid && cdb_idx == qN_idx)).
  - qN_data selects cdb_data on a same-cycle bypass, otherwise the stored data.
  - A lookup to a non-busy entry gives ready 0, data 0.
- Wrap: with DEPTH entries allocated, tail == head, full = 1; count distinguishes full from empty.

Decomposition:
- rob_pkg holds:
  - ROB_INDEX_BITS default
  - rob_entry_t struct {logic busy; logic ready; logic [4:0] rd; logic [31:0] data;}
  - shared with reservation stations and dispatch so tag widths stay consistent.
- No sub-module: a single module holding the entry array, pointers and lookup muxes.

Test Plan:
- Reset, then alloc rd=5 -> alloc_idx=0, count 1. CDB idx0 data 0xDEADBEEF -> next cycle commit_valid=1, commit_rd=5, commit_data=0xDEADBEEF, rob_head=0; then empty=1.
- Out-of-order completion: alloc rd=1,2,3 (tags 0,1,2); CDB tag2=0x33, then tag1=0x22, then tag0=0x11 -> commits in order: rd1=0x11, rd2=0x22, rd3=0x33 on consecutive cycles.
- Fill 16 entries -> full=1, alloc_ready=0. A 17th alloc_req is ignored and tail is unchanged. Commit tag0 -> next cycle alloc_idx=0 and the allocation is accepted (wrap-around).
- Lookup bypass: tag 3 busy and not ready; in the same cycle cdb_valid idx3 data 0x1234 with q1_idx=3 -> q1_ready=1, q1_data=0x1234. Next cycle, without CDB, still ready with 0x1234.
- Flush with 5 busy entries and a simultaneous alloc_req and CDB -> next cycle empty=1, head=tail=0, commit_valid=0, and the CDB write was discarded.
- Simultaneous alloc and commit at count=4 -> count stays 4; head and tail both increment.
